// File: rtl/kuyruk_pkg.sv
// Shared definitions for the queue sequencer: state encoding, entry layout
// and the entry-count clamp.
package kuyruk_pkg;

    localparam int GIRDI_W     = 8;   // one queue entry
    localparam int SLOT_SAYISI = 4;   // entries held in the packed word
    localparam int KUYRUK_W    = GIRDI_W * SLOT_SAYISI;
    localparam int SAYI_W      = 3;

    // Field positions inside one entry: {veri[4:0], bekleme[2:0]}
    localparam int VERI_MSB    = 7;
    localparam int VERI_LSB    = 3;
    localparam int BEKLEME_MSB = 2;
    localparam int BEKLEME_LSB = 0;
    localparam int VERI_W      = VERI_MSB - VERI_LSB + 1;
    localparam int BEKLEME_W   = BEKLEME_MSB - BEKLEME_LSB + 1;

    // The head entry occupies the top byte of the queue word
    localparam int BAS_LSB     = KUYRUK_W - GIRDI_W;

    typedef enum logic [1:0] {
        BOSTA = 2'd0,
        BEKLE = 2'd1,
        CIKIS = 2'd2,
        BITTI = 2'd3
    } durum_t;

    // Counts above the slot count are treated as a full queue
    function automatic logic [SAYI_W-1:0] sayi_kisitla(input logic [SAYI_W-1:0] n);
        logic [SAYI_W-1:0] maks;
        maks = SAYI_W'(SLOT_SAYISI);
        return (n > maks) ? maks : n;
    endfunction

endpackage

// File: rtl/kuyruk_adim.sv
// One combinational step of the queue: either pop the head (shift left by
// one entry, zero-fill, one fewer remaining) or count the head's wait down.
module kuyruk_adim
    import kuyruk_pkg::*;
(
    input  logic [KUYRUK_W-1:0] kuyruk,
    input  logic [SAYI_W-1:0]   kalan,
    input  logic                cek,
    output logic [KUYRUK_W-1:0] sonraki_kuyruk,
    output logic [SAYI_W-1:0]   sonraki_kalan,
    output logic                bekleme_sifir
);

    logic [BEKLEME_W-1:0] bas_bekleme;

    assign bas_bekleme   = kuyruk[BAS_LSB+BEKLEME_MSB:BAS_LSB+BEKLEME_LSB];
    assign bekleme_sifir = (bas_bekleme == '0);

    // Pop takes precedence; otherwise decrement the head wait, holding at zero
    always_comb begin
        sonraki_kuyruk = kuyruk;
        sonraki_kalan  = kalan;
        if (cek) begin
            sonraki_kuyruk = kuyruk << GIRDI_W;
            sonraki_kalan  = (kalan != '0) ? kalan - 1'b1 : '0;
        end else if (!bekleme_sifir) begin
            sonraki_kuyruk[BAS_LSB+BEKLEME_MSB:BAS_LSB+BEKLEME_LSB] = bas_bekleme - 1'b1;
        end
    end

endmodule

// File: rtl/kuyruk_sirayici.sv
// Queue sequencer: loads up to four {data, wait} entries, counts each head
// entry's wait down, then offers its data on a valid/ready output and pops.
//
// Output handshake: cikis_gecerli is high only in CIKIS and, once high,
// cikan_veri stays constant until a rising edge sees cikis_gecerli and
// cikis_hazir both high; that edge is the transfer. cikan_veri is zero
// whenever cikis_gecerli is low. iptal outranks a transfer on the same edge.
module kuyruk_sirayici
    import kuyruk_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                yukle,
    input  logic [KUYRUK_W-1:0] kuyruk_giris,
    input  logic [SAYI_W-1:0]   eleman_sayisi,
    input  logic                iptal,
    input  logic                cikis_hazir,
    output logic                cikis_gecerli,
    output logic [VERI_W-1:0]   cikan_veri,
    output logic [BEKLEME_W-1:0] cevrim_sayisi,
    output logic [SAYI_W-1:0]   kalan_sayi,
    output logic [KUYRUK_W-1:0] yeni_kuyruk,
    output logic                mesgul,
    output logic                bitti,
    output durum_t              durum_dbg
);

    durum_t              durum, durum_n;
    logic [KUYRUK_W-1:0] kuyruk_n;
    logic [SAYI_W-1:0]   kalan_n;
    logic [SAYI_W-1:0]   giris_sayi;

    logic                cek;
    logic [KUYRUK_W-1:0] adim_kuyruk;
    logic [SAYI_W-1:0]   adim_kalan;
    logic                bekleme_sifir;

    assign giris_sayi = sayi_kisitla(eleman_sayisi);
    assign cek        = (durum == CIKIS) && cikis_hazir;

    kuyruk_adim u_adim (
        .kuyruk         (yeni_kuyruk),
        .kalan          (kalan_sayi),
        .cek            (cek),
        .sonraki_kuyruk (adim_kuyruk),
        .sonraki_kalan  (adim_kalan),
        .bekleme_sifir  (bekleme_sifir)
    );

    // State, queue word and remaining count; reset discards everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum       <= BOSTA;
            yeni_kuyruk <= '0;
            kalan_sayi  <= '0;
        end else begin
            durum       <= durum_n;
            yeni_kuyruk <= kuyruk_n;
            kalan_sayi  <= kalan_n;
        end
    end

    // Next-state and next-queue selection; abort overrides every other path
    always_comb begin
        durum_n  = durum;
        kuyruk_n = yeni_kuyruk;
        kalan_n  = kalan_sayi;
        case (durum)
            BOSTA: begin
                if (yukle) begin
                    kuyruk_n = kuyruk_giris;
                    kalan_n  = giris_sayi;
                    durum_n  = (giris_sayi == '0) ? BITTI : BEKLE;
                end
            end
            BEKLE: begin
                if (bekleme_sifir) begin
                    durum_n = CIKIS;
                end else begin
                    kuyruk_n = adim_kuyruk;
                end
            end
            CIKIS: begin
                if (cek) begin
                    kuyruk_n = adim_kuyruk;
                    kalan_n  = adim_kalan;
                    durum_n  = (adim_kalan == '0) ? BITTI : BEKLE;
                end
            end
            BITTI: begin
                durum_n = BOSTA;
            end
            default: begin
                durum_n = BOSTA;
            end
        endcase
        if (iptal && (durum != BOSTA)) begin
            durum_n  = BOSTA;
            kuyruk_n = '0;
            kalan_n  = '0;
        end
    end

    assign cikis_gecerli = (durum == CIKIS);
    assign cikan_veri    = cikis_gecerli ? yeni_kuyruk[BAS_LSB+VERI_MSB:BAS_LSB+VERI_LSB] : '0;
    assign cevrim_sayisi = yeni_kuyruk[BAS_LSB+BEKLEME_MSB:BAS_LSB+BEKLEME_LSB];
    assign mesgul        = (durum != BOSTA);
    assign bitti         = (durum == BITTI);
    assign durum_dbg     = durum;

endmodule

// File: doc/kuyruk_sirayici.md
KUYRUK_SIRAYICI -- requirements
Module: kuyruk_sirayici

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-003 SHALL have port yukle, input, 1: load request; sampled only in BOSTA.
REQ-004 SHALL have port kuyruk_giris, input, 32: packed queue of four 8-bit entries {veri[4:0], bekleme[2:0]}; head is [31:24].
REQ-005 SHALL have port eleman_sayisi, input, 3: number of valid entries; values above 4 clamp to 4.
REQ-006 SHALL have port iptal, input, 1: abort the current operation.
REQ-007 SHALL have port cikis_hazir, input, 1: consumer ready.
REQ-008 SHALL have port cikis_gecerli, output, 1: cikan_veri valid.
REQ-009 SHALL have port cikan_veri, output, 5: head entry data.
REQ-010 SHALL have port cevrim_sayisi, output, 3: remaining wait cycles of the head entry.
REQ-011 SHALL have port kalan_sayi, output, 3: entries not yet popped.
REQ-012 SHALL have port yeni_kuyruk, output, 32: current internal queue register.
REQ-013 SHALL have port mesgul, output, 1: high in every state except BOSTA.
REQ-014 SHALL have port bitti, output, 1: one-cycle completion pulse.

Function
REQ-015 SHALL implement the FSM states BOSTA, BEKLE, CIKIS and BITTI.
REQ-016 In BOSTA, yukle=1 SHALL register kuyruk_giris and the clamped count, then go to BEKLE; if the count is 0, it SHALL go to BITTI instead.
REQ-017 In BEKLE with head bekleme!=0, the FSM SHALL decrement yeni_kuyruk[26:24] by 1 per cycle, with no wrap below 0.
REQ-018 In BEKLE with head bekleme==0, the FSM SHALL go to CIKIS on the next edge.
REQ-019 In CIKIS, cikis_gecerli SHALL be 1, and cikan_veri SHALL equal yeni_kuyruk[31:27] and stay stable until handshake.
REQ-020 A handshake SHALL be cikis_gecerli & cikis_hazir at a rising edge; on handshake the block SHALL shift yeni_kuyruk left by 8 (zero-fill) and decrement kalan_sayi.
REQ-021 After a handshake the FSM SHALL go to BITTI if kalan_sayi reaches 0, otherwise to BEKLE.
REQ-022 Latency SHALL be w+1 cycles: an entry with bekleme=w is valid w+1 cycles after entering BEKLE.
REQ-023 BITTI SHALL assert bitti for exactly one cycle and then return to BOSTA.
REQ-024 yukle SHALL be ignored while mesgul=1.
REQ-025 iptal=1 in any state other than BOSTA SHALL force BOSTA on the next edge, clear all outputs to their reset values, and suppress bitti.
REQ-026 iptal SHALL take priority over a simultaneous handshake, so no pop occurs.
REQ-027 cikan_veri SHALL be 0 whenever cikis_gecerli=0.
REQ-028 cevrim_sayisi SHALL always reflect yeni_kuyruk[26:24].

Reset
REQ-029 While rst_n=0, the block SHALL immediately force state BOSTA and set cikis_gecerli, cikan_veri, cevrim_sayisi, kalan_sayi, yeni_kuyruk, mesgul and bitti to 0.
REQ-030 A reset asserted mid-operation SHALL discard the queue without producing a bitti pulse.

Structure
REQ-031 A shared package kuyruk_pkg SHALL hold the state encoding, entry width 8, slot count 4, data field [7:3] and wait field [2:0].
REQ-032 The combinational single-step logic (decrement or pop-and-shift) SHALL be a sub-module kuyruk_adim instantiated once.

Verification
REQ-033 Single entry: load 0x18000000 with count 1 and hazir=1 -> cikis_gecerli=1 with cikan_veri=3 one cycle after the load edge; bitti pulses after the handshake edge; the block returns to BOSTA.
REQ-034 Wait countdown: load 0xFA180000 with count 2 -> cevrim_sayisi reads 2, 1, 0; 0x1F is valid 3 cycles after load, then 0x03; yeni_kuyruk reads 0x18000000 after the first pop.
REQ-035 Backpressure: hold hazir=0 for 5 cycles during CIKIS -> cikis_gecerli and cikan_veri are held constant, and no shift occurs.
REQ-036 Count boundaries: count 0 -> bitti the cycle after load with no valid; count 7 -> exactly 4 pops and kalan_sayi reads 4 after load.
REQ-037 Abort and reset: iptal during BEKLE -> BOSTA next cycle with no bitti; rst_n low during CIKIS -> all outputs 0 without waiting for a clock edge.
REQ-038 Busy load: yukle pulsed with a new word during BEKLE -> no effect; the original queue completes unchanged.
